// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared opcodes, widths and FSM encoding for the EX stage
package ex_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_XOR  = 6'd5;
    localparam logic [5:0] OP_SLT  = 6'd6;
    localparam logic [5:0] OP_ADDI = 6'd7;
    localparam logic [5:0] OP_LW   = 6'd8;
    localparam logic [5:0] OP_SW   = 6'd9;
    localparam logic [5:0] OP_BEQ  = 6'd10;
    localparam logic [5:0] OP_BNE  = 6'd11;
    localparam logic [5:0] OP_MUL  = 6'd12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_t;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/ex_if.sv
// rtl/ex_if.sv - decode-to-EX issue and EX-to-memory result bundle
interface ex_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    opcode;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] sign_e;
    logic [DW-1:0] npc;
    logic [RW-1:0] target;
    logic [RW-1:0] dest;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] store_data;
    logic [RW-1:0] wb_reg;
    logic          wb_en;
    logic          mem_rd;
    logic          mem_wr;
    logic          br_taken;
    logic [DW-1:0] br_target;
    logic          ovf;
    logic          illegal;

    modport slave (
        input  in_valid, opcode, a, b, sign_e, npc, target, dest, out_ready,
        output in_ready, out_valid, alu_out, store_data, wb_reg, wb_en,
               mem_rd, mem_wr, br_taken, br_target, ovf, illegal
    );

    modport master (
        output in_valid, opcode, a, b, sign_e, npc, target, dest, out_ready,
        input  in_ready, out_valid, alu_out, store_data, wb_reg, wb_en,
               mem_rd, mem_wr, br_taken, br_target, ovf, illegal
    );
endinterface

// File: rtl/ex_mul_seq.sv
// rtl/ex_mul_seq.sv - iterative shift-add multiplier, one multiplier bit per cycle
module ex_mul_seq #(
    parameter int DW         = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          done,
    output logic [DW-1:0] product
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    logic          running;
    logic [CW-1:0] cnt;
    logic [DW-1:0] acc;
    logic [DW-1:0] mcand;
    logic [DW-1:0] mplier;
    logic [DW-1:0] step_sum;

    assign step_sum = acc + (mplier[0] ? mcand : '0);
    // The final partial product is folded in combinationally so the result
    // is ready on the same edge as the last iteration.
    assign done     = running && (cnt == LAST);
    assign product  = step_sum;

    always_ff @(posedge clk) begin
        if (!reset) begin
            running <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= a;
            mplier  <= b;
        end else if (running) begin
            acc     <= step_sum;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + 1'b1;
            if (done)
                running <= 1'b0;
        end
    end
endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - MIPS EX stage: ALU, address calc, branch resolve, optional MUL (EX_MUL_EN)
module execute_stage
    import ex_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int RW         = RW_DEF,
    parameter int MUL_CYCLES = DW_DEF
) (
    input logic clk,
    input logic reset,
    ex_if.slave bus
);
    logic          accept;
    logic          out_free;
    logic          is_mul;

    logic [DW-1:0] sum_ab;
    logic [DW-1:0] diff_ab;
    logic [DW-1:0] sum_ai;
    logic [DW-1:0] br_tgt;

    logic [DW-1:0] r_alu;
    logic [RW-1:0] r_wbreg;
    logic          r_wben;
    logic          r_rd;
    logic          r_wr;
    logic          r_br;
    logic          r_ovf;
    logic          r_ill;

    logic [DW-1:0] q_alu;
    logic [DW-1:0] q_store;
    logic [RW-1:0] q_wbreg;
    logic [DW-1:0] q_brt;
    logic          q_valid;
    logic          q_wben;
    logic          q_rd;
    logic          q_wr;
    logic          q_br;
    logic          q_ovf;
    logic          q_ill;

    logic          mul_start;
    logic          mul_done;
    logic [DW-1:0] mul_product;

    assign out_free = !q_valid || bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;

`ifdef EX_MUL_EN
    ex_state_t     state_q;
    ex_state_t     state_d;
    logic [RW-1:0] mul_dest_q;

    assign is_mul       = (bus.opcode == OP_MUL);
    assign bus.in_ready = reset && (state_q == ST_IDLE) && out_free;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            mul_dest_q <= '0;
        end else begin
            state_q <= state_d;
            if (mul_start)
                mul_dest_q <= bus.dest;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
            ST_MUL:  if (mul_done)         state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mul_start = 1'b0;
        if (state_q == ST_IDLE)
            mul_start = accept && is_mul;
    end

    ex_mul_seq #(
        .DW         (DW),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul       = 1'b0;
    assign mul_start    = 1'b0;
    assign mul_done     = 1'b0;
    assign mul_product  = '0;
    assign bus.in_ready = reset && out_free;
`endif

    assign sum_ab  = bus.a + bus.b;
    assign diff_ab = bus.a - bus.b;
    assign sum_ai  = bus.a + bus.sign_e;
    assign br_tgt  = bus.npc + (bus.sign_e << 2);

    always_comb begin
        r_alu   = '0;
        r_wbreg = '0;
        r_wben  = 1'b0;
        r_rd    = 1'b0;
        r_wr    = 1'b0;
        r_br    = 1'b0;
        r_ovf   = 1'b0;
        r_ill   = 1'b0;
        case (bus.opcode)
            OP_NOP: ;
            OP_ADD: begin
                r_alu   = sum_ab;
                r_wbreg = bus.dest;
                r_wben  = 1'b1;
                r_ovf   = add_ovf(bus.a[DW-1], bus.b[DW-1], sum_ab[DW-1]);
            end
            OP_SUB: begin
                r_alu   = diff_ab;
                r_wbreg = bus.dest;
                r_wben  = 1'b1;
                r_ovf   = add_ovf(bus.a[DW-1], !bus.b[DW-1], diff_ab[DW-1]);
            end
            OP_AND: begin r_alu = bus.a & bus.b; r_wbreg = bus.dest; r_wben = 1'b1; end
            OP_OR:  begin r_alu = bus.a | bus.b; r_wbreg = bus.dest; r_wben = 1'b1; end
            OP_XOR: begin r_alu = bus.a ^ bus.b; r_wbreg = bus.dest; r_wben = 1'b1; end
            OP_SLT: begin
                r_alu   = {{(DW-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
                r_wbreg = bus.dest;
                r_wben  = 1'b1;
            end
            OP_ADDI: begin
                r_alu   = sum_ai;
                r_wbreg = bus.target;
                r_wben  = 1'b1;
                r_ovf   = add_ovf(bus.a[DW-1], bus.sign_e[DW-1], sum_ai[DW-1]);
            end
            OP_LW: begin
                r_alu   = sum_ai;
                r_wbreg = bus.target;
                r_wben  = 1'b1;
                r_rd    = 1'b1;
            end
            OP_SW: begin
                r_alu = sum_ai;
                r_wr  = 1'b1;
            end
            OP_BEQ: r_br = (bus.a == bus.b);
            OP_BNE: r_br = (bus.a != bus.b);
`ifdef EX_MUL_EN
            OP_MUL: ;
`endif
            default: r_ill = 1'b1;
        endcase
    end

    // Result register: loads on a single-cycle accept or multiply completion,
    // otherwise holds until the memory stage takes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_valid <= 1'b0;
            q_alu   <= '0;
            q_store <= '0;
            q_wbreg <= '0;
            q_brt   <= '0;
            q_wben  <= 1'b0;
            q_rd    <= 1'b0;
            q_wr    <= 1'b0;
            q_br    <= 1'b0;
            q_ovf   <= 1'b0;
            q_ill   <= 1'b0;
        end else if (accept && !is_mul) begin
            q_valid <= 1'b1;
            q_alu   <= r_alu;
            q_store <= bus.b;
            q_wbreg <= r_wbreg;
            q_brt   <= br_tgt;
            q_wben  <= r_wben;
            q_rd    <= r_rd;
            q_wr    <= r_wr;
            q_br    <= r_br;
            q_ovf   <= r_ovf;
            q_ill   <= r_ill;
        end else if (mul_done) begin
            q_valid <= 1'b1;
            q_alu   <= mul_product;
`ifdef EX_MUL_EN
            q_wbreg <= mul_dest_q;
`endif
            q_wben  <= 1'b1;
            q_rd    <= 1'b0;
            q_wr    <= 1'b0;
            q_br    <= 1'b0;
            q_ovf   <= 1'b0;
            q_ill   <= 1'b0;
        end else if (bus.out_ready) begin
            q_valid <= 1'b0;
        end
    end

    assign bus.out_valid  = q_valid;
    assign bus.alu_out    = q_alu;
    assign bus.store_data = q_store;
    assign bus.wb_reg     = q_wbreg;
    assign bus.wb_en      = q_wben;
    assign bus.mem_rd     = q_rd;
    assign bus.mem_wr     = q_wr;
    assign bus.br_taken   = q_br;
    assign bus.br_target  = q_brt;
    assign bus.ovf        = q_ovf;
    assign bus.illegal    = q_ill;
endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed table-driven bench for execute_stage
module tb_execute_stage;
    import ex_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    ex_if #(.DW(32), .RW(5)) bus ();

    execute_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] se;
        logic [31:0] npc;
        logic [4:0]  tgt;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [4:0]  wbr;
        logic [5:0]  ctl;   // {wb_en, mem_rd, mem_wr, br_taken, ovf, illegal}
        logic [31:0] brt;
        logic [31:0] sd;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] se, input logic [31:0] npc, input logic [4:0] tgt,
                                input logic [4:0] dst, input logic [31:0] alu, input logic [4:0] wbr,
                                input logic [5:0] ctl, input logic [31:0] brt);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.se = se; v.npc = npc; v.tgt = tgt; v.dst = dst;
        v.alu = alu; v.wbr = wbr; v.ctl = ctl; v.brt = brt; v.sd = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] ctl_now();
        return {bus.wb_en, bus.mem_rd, bus.mem_wr, bus.br_taken, bus.ovf, bus.illegal};
    endfunction

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] se, input logic [31:0] npc, input logic [4:0] tgt,
                         input logic [4:0] dst);
        bus.opcode = op; bus.a = a; bus.b = b; bus.sign_e = se;
        bus.npc = npc; bus.target = tgt; bus.dest = dst;
        bus.in_valid = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_alu_out"},   bus.alu_out, 32'd0);
        check({tag, "_ctl"},       32'(ctl_now()), 32'd0);
        check({tag, "_wb_reg"},    32'(bus.wb_reg), 32'd0);
        check({tag, "_br_target"}, bus.br_target, 32'd0);
    endtask

    initial begin
        int n;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(OP_NOP, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b0;

        vecs[0]  = mk(OP_ADD,  32'd5,        32'd7, 0, 0, 0, 5'd1, 32'd12,        5'd1, 6'b100000, 0);
        vecs[1]  = mk(OP_SUB,  32'd3,        32'd5, 0, 0, 0, 5'd3, 32'hFFFFFFFE,  5'd3, 6'b100000, 0);
        vecs[2]  = mk(OP_ADD,  32'h7FFFFFFF, 32'd1, 0, 0, 0, 5'd7, 32'h80000000,  5'd7, 6'b100010, 0);
        vecs[3]  = mk(OP_SLT,  32'hFFFFFFFF, 32'd1, 0, 0, 0, 5'd4, 32'd1,         5'd4, 6'b100000, 0);
        vecs[4]  = mk(OP_SUB,  32'h80000000, 32'd1, 0, 0, 0, 5'd8, 32'h7FFFFFFF,  5'd8, 6'b100010, 0);
        vecs[5]  = mk(OP_AND,  32'h0000F0F0, 32'h0000FF00, 0, 0, 0, 5'd9,  32'h0000F000, 5'd9,  6'b100000, 0);
        vecs[6]  = mk(OP_OR,   32'h0000F0F0, 32'h0000FF00, 0, 0, 0, 5'd10, 32'h0000FFF0, 5'd10, 6'b100000, 0);
        vecs[7]  = mk(OP_XOR,  32'h0000F0F0, 32'h0000FF00, 0, 0, 0, 5'd11, 32'h00000FF0, 5'd11, 6'b100000, 0);
        vecs[8]  = mk(OP_ADDI, 32'd10, 0, 32'hFFFFFFFF, 0, 5'd6, 5'd20, 32'd9,      5'd6, 6'b100000, 0);
        vecs[9]  = mk(OP_LW,   32'h1000, 0, 32'h10, 0, 5'd2, 5'd21, 32'h1010,       5'd2, 6'b110000, 0);
        vecs[10] = mk(OP_SW,   32'h20, 32'hDEAD, 32'h4, 0, 5'd3, 5'd22, 32'h24,     5'd0, 6'b001000, 0);
        vecs[11] = mk(OP_BEQ,  32'd9, 32'd9, 32'hFFFFFFFE, 32'h100, 0, 0, 32'd0,    5'd0, 6'b000100, 32'hF8);
        vecs[12] = mk(OP_BNE,  32'd9, 32'd9, 32'hFFFFFFFE, 32'h100, 0, 0, 32'd0,    5'd0, 6'b000000, 32'hF8);
        vecs[13] = mk(6'd63,   32'd1, 32'd2, 0, 0, 5'd5, 5'd6, 32'd0,               5'd0, 6'b000001, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_zero_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Single-cycle table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].se, vecs[i].npc, vecs[i].tgt, vecs[i].dst);
            bus.out_ready = 1'b1;
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("v%0d_alu_out", i), bus.alu_out, vecs[i].alu);
            check($sformatf("v%0d_wb_reg", i), 32'(bus.wb_reg), 32'(vecs[i].wbr));
            check($sformatf("v%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
            if (vecs[i].op == OP_BEQ || vecs[i].op == OP_BNE)
                check($sformatf("v%0d_br_target", i), bus.br_target, vecs[i].brt);
            if (vecs[i].op == OP_SW)
                check($sformatf("v%0d_store_data", i), bus.store_data, vecs[i].sd);
        end

        // Back-pressure: LW held for 3 cycles, then back-to-back accept
        @(negedge clk);
        drive(OP_LW, 32'h1000, 32'd0, 32'h10, 32'd0, 5'd2, 5'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        drive(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 5'd0, 5'd5);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
            check($sformatf("hold%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("hold%0d_alu_out", c), bus.alu_out, 32'h1010);
            check($sformatf("hold%0d_mem_rd", c), 32'(bus.mem_rd), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("b2b_out_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_alu_out", bus.alu_out, 32'd3);
        check("b2b_wb_reg", 32'(bus.wb_reg), 32'd5);
        check("b2b_mem_rd", 32'(bus.mem_rd), 32'd0);
        @(posedge clk);
        #1;
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);

`ifdef EX_MUL_EN
        // MUL latency and result
        @(negedge clk);
        drive(OP_MUL, 32'd6, 32'd7, 32'd0, 32'd0, 5'd0, 5'd9);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            if (bus.in_ready !== 1'b0) begin
                n_tests++; n_fail++;
                $display("FAIL mul_in_ready: got %b expected 0 at cycle %0d", bus.in_ready, n);
            end
            @(posedge clk);
            #1;
            n++;
        end
        check("mul_latency", 32'(n), 32'd32);
        check("mul_alu_out", bus.alu_out, 32'd42);
        check("mul_wb_reg", 32'(bus.wb_reg), 32'd9);
        check("mul_ctl", 32'(ctl_now()), 32'b100000);

        @(negedge clk);
        drive(OP_MUL, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 5'd0, 5'd12);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mulneg_latency", 32'(n), 32'd32);
        check("mulneg_alu_out", bus.alu_out, 32'hFFFFFFF1);

        // Reset mid-multiply aborts it
        @(negedge clk);
        drive(OP_MUL, 32'd3, 32'd3, 32'd0, 32'd0, 5'd0, 5'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
`else
        // MUL is illegal without the multiplier
        @(negedge clk);
        drive(OP_MUL, 32'd6, 32'd7, 32'd0, 32'd0, 5'd0, 5'd9);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("mul_ill_out_valid", 32'(bus.out_valid), 32'd1);
        check("mul_ill_ctl", 32'(ctl_now()), 32'b000001);
        check("mul_ill_in_ready", 32'(bus.in_ready), 32'd1);

        @(negedge clk);
        drive(OP_ADD, 32'd3, 32'd3, 32'd0, 32'd0, 5'd0, 5'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_zero_outputs("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rel_out_valid", 32'(bus.out_valid), 32'd0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) n++;
        end
        check("abort_no_result", 32'(n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
